// File: rtl/scale_mem_ctrl.sv
// -----------------------------------------------------------------------------
// scale_mem_ctrl
//   Memory sequencer for the image path. Executes single-pixel reads/writes and
//   whole-frame scaling passes (1:1 copy, 2x zoom, 2x decimation, 2x2 average)
//   from a source image in the read RAM to a centred window of the destination
//   framebuffer in the write RAM.
//
// Ports
//   i_clock       system clock, rising edge
//   i_reset_n     synchronous active-low reset
//   i_start       command strobe, accepted only while idle
//   i_operation   001 RD, 010 WR, 011 ZOOM2, 100 DEC2, 101 AVG2, 110 COPY
//   i_abort       terminate the current command
//   i_addr_in     address for RD/WR
//   i_data_in     write data for WR
//   o_rd_addr     read RAM address (registered)
//   i_rd_data     read RAM data, valid RD_LAT cycles after o_rd_addr
//   o_wr_addr     write RAM address (registered)
//   o_wr_data     write RAM data (registered)
//   o_wr_en       write strobe, one cycle per pixel
//   o_data_out    result of the last RD
//   o_busy        command in progress
//   o_done        one-cycle completion pulse
//   o_err         with o_done: reserved opcode or abort
//   o_pix_count   pixels written by the current/last command
//   o_state_dbg   FSM state code
// -----------------------------------------------------------------------------
module scale_mem_ctrl #(
    parameter int unsigned ADDR_W   = 17,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned SRC_W    = 160,
    parameter int unsigned SRC_H    = 120,
    parameter int unsigned DST_W    = 320,
    parameter int unsigned DST_H    = 240,
    parameter int unsigned SRC_BASE = 0,
    parameter int unsigned DST_BASE = 0,
    parameter int unsigned RD_LAT   = 2
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic [2:0]        i_operation,
    input  logic              i_abort,
    input  logic [ADDR_W-1:0] i_addr_in,
    input  logic [DATA_W-1:0] i_data_in,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_wr_en,
    output logic [DATA_W-1:0] o_data_out,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [ADDR_W-1:0] o_pix_count,
    output logic [2:0]        o_state_dbg
);

    localparam logic [2:0] OP_RD    = 3'b001;
    localparam logic [2:0] OP_WR    = 3'b010;
    localparam logic [2:0] OP_ZOOM2 = 3'b011;
    localparam logic [2:0] OP_DEC2  = 3'b100;
    localparam logic [2:0] OP_AVG2  = 3'b101;
    localparam logic [2:0] OP_COPY  = 3'b110;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SGL_RD  = 3'd1;
    localparam logic [2:0] S_SGL_WR  = 3'd2;
    localparam logic [2:0] S_PX_RD   = 3'd3;
    localparam logic [2:0] S_PX_WAIT = 3'd4;
    localparam logic [2:0] S_PX_WR   = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    // Coordinate, latency-counter and accumulator widths
    localparam int unsigned CW = $clog2((DST_W > DST_H) ? DST_W : DST_H) + 1;
    localparam int unsigned WW = $clog2(RD_LAT + 1) + 1;
    localparam int unsigned AW = DATA_W + 2;

    function automatic logic [31:0] f_out_w(input logic [2:0] op);
        case (op)
            OP_ZOOM2:         return 2 * SRC_W;
            OP_DEC2, OP_AVG2: return SRC_W / 2;
            default:          return SRC_W;
        endcase
    endfunction

    function automatic logic [31:0] f_out_h(input logic [2:0] op);
        case (op)
            OP_ZOOM2:         return 2 * SRC_H;
            OP_DEC2, OP_AVG2: return SRC_H / 2;
            default:          return SRC_H;
        endcase
    endfunction

    // Source address of tap k for output pixel (ox, oy), full precision then truncated
    function automatic logic [ADDR_W-1:0] f_src_addr(input logic [2:0]    op,
                                                     input logic [CW-1:0] ox,
                                                     input logic [CW-1:0] oy,
                                                     input logic [1:0]    tap);
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] sx;
        logic [31:0] sy;
        x  = 32'(ox);
        y  = 32'(oy);
        sx = x;
        sy = y;
        case (op)
            OP_ZOOM2: begin
                sx = x >> 1;
                sy = y >> 1;
            end
            OP_DEC2: begin
                sx = x << 1;
                sy = y << 1;
            end
            OP_AVG2: begin
                sx = (x << 1) + 32'(tap[0]);
                sy = (y << 1) + 32'(tap[1]);
            end
            default: ;
        endcase
        return ADDR_W'(SRC_BASE + sy * SRC_W + sx);
    endfunction

    // Destination address: output window is centred in the destination frame
    function automatic logic [ADDR_W-1:0] f_dst_addr(input logic [2:0]    op,
                                                     input logic [CW-1:0] ox,
                                                     input logic [CW-1:0] oy);
        logic [31:0] offx;
        logic [31:0] offy;
        offx = (DST_W - f_out_w(op)) / 2;
        offy = (DST_H - f_out_h(op)) / 2;
        return ADDR_W'(DST_BASE + (32'(oy) + offy) * DST_W + 32'(ox) + offx);
    endfunction

    logic [2:0]        r_state;
    logic [2:0]        r_op;
    logic [CW-1:0]     r_ox;
    logic [CW-1:0]     r_oy;
    logic [1:0]        r_tap;
    logic [WW-1:0]     r_wait;
    logic [AW-1:0]     r_acc;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_wr_en;
    logic [DATA_W-1:0] r_data_out;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [ADDR_W-1:0] r_pix_count;

    logic [1:0]        w_tap_last;
    logic [CW-1:0]     w_last_x;
    logic [CW-1:0]     w_last_y;
    logic [CW-1:0]     w_next_x;
    logic [CW-1:0]     w_next_y;
    logic [AW-1:0]     w_acc_sum;
    logic [DATA_W-1:0] w_pix;

    always_comb begin
        w_tap_last = (r_op == OP_AVG2) ? 2'd3 : 2'd0;
        w_last_x   = CW'(f_out_w(r_op) - 32'd1);
        w_last_y   = CW'(f_out_h(r_op) - 32'd1);
        // Tap 0 starts a fresh sum so no separate clear cycle is needed
        w_acc_sum  = ((r_tap == 2'd0) ? '0 : r_acc) + AW'(i_rd_data);
        w_pix      = (r_op == OP_AVG2) ? w_acc_sum[DATA_W+1:2] : w_acc_sum[DATA_W-1:0];
        if (r_ox == w_last_x) begin
            w_next_x = '0;
            w_next_y = r_oy + 1'b1;
        end else begin
            w_next_x = r_ox + 1'b1;
            w_next_y = r_oy;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_ox        <= '0;
            r_oy        <= '0;
            r_tap       <= '0;
            r_wait      <= '0;
            r_acc       <= '0;
            r_rd_addr   <= '0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_wr_en     <= 1'b0;
            r_data_out  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_pix_count <= '0;
        end else begin
            r_wr_en <= 1'b0;
            // A write presented this cycle lands at this edge even if abort is also set
            if (r_state == S_PX_WR || r_state == S_SGL_WR) begin
                r_pix_count <= r_pix_count + 1'b1;
            end
            if (i_abort && r_busy) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_err   <= 1'b1;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start && !i_abort) begin
                            r_op        <= i_operation;
                            r_pix_count <= '0;
                            r_ox        <= '0;
                            r_oy        <= '0;
                            r_tap       <= '0;
                            r_wait      <= '0;
                            case (i_operation)
                                OP_RD: begin
                                    r_busy    <= 1'b1;
                                    r_rd_addr <= i_addr_in;
                                    r_state   <= S_SGL_RD;
                                end
                                OP_WR: begin
                                    r_busy    <= 1'b1;
                                    r_wr_addr <= i_addr_in;
                                    r_wr_data <= i_data_in;
                                    r_wr_en   <= 1'b1;
                                    r_state   <= S_SGL_WR;
                                end
                                OP_ZOOM2, OP_DEC2, OP_AVG2, OP_COPY: begin
                                    r_busy    <= 1'b1;
                                    r_rd_addr <= f_src_addr(i_operation, '0, '0, 2'd0);
                                    r_state   <= S_PX_RD;
                                end
                                default: begin
                                    r_state <= S_DONE;
                                    r_done  <= 1'b1;
                                    r_err   <= 1'b1;
                                end
                            endcase
                        end
                    end
                    S_SGL_RD: begin
                        // Address cycle plus RD_LAT wait cycles, sample on the last
                        if (r_wait == WW'(RD_LAT)) begin
                            r_data_out <= i_rd_data;
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_err      <= 1'b0;
                            r_busy     <= 1'b0;
                        end else begin
                            r_wait <= r_wait + 1'b1;
                        end
                    end
                    S_SGL_WR: begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                    S_PX_RD: begin
                        r_wait  <= WW'(1);
                        r_state <= S_PX_WAIT;
                    end
                    S_PX_WAIT: begin
                        if (r_wait == WW'(RD_LAT)) begin
                            r_acc <= w_acc_sum;
                            if (r_tap == w_tap_last) begin
                                r_wr_en   <= 1'b1;
                                r_wr_addr <= f_dst_addr(r_op, r_ox, r_oy);
                                r_wr_data <= w_pix;
                                r_state   <= S_PX_WR;
                            end else begin
                                r_tap     <= r_tap + 2'd1;
                                r_rd_addr <= f_src_addr(r_op, r_ox, r_oy, r_tap + 2'd1);
                                r_state   <= S_PX_RD;
                            end
                        end else begin
                            r_wait <= r_wait + 1'b1;
                        end
                    end
                    S_PX_WR: begin
                        if (r_ox == w_last_x && r_oy == w_last_y) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_ox      <= w_next_x;
                            r_oy      <= w_next_y;
                            r_tap     <= 2'd0;
                            r_rd_addr <= f_src_addr(r_op, w_next_x, w_next_y, 2'd0);
                            r_state   <= S_PX_RD;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_rd_addr   = r_rd_addr;
    assign o_wr_addr   = r_wr_addr;
    assign o_wr_data   = r_wr_data;
    assign o_wr_en     = r_wr_en;
    assign o_data_out  = r_data_out;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_pix_count = r_pix_count;
    assign o_state_dbg = r_state;

endmodule

// File: tb/tb_scale_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scale_mem_ctrl
//   Randomised self-checking bench for scale_mem_ctrl on a reduced frame size.
//   Expected frame writes come from a pixel-level model of the scaling rules.
// -----------------------------------------------------------------------------
module tb_scale_mem_ctrl;

    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned SRC_W    = 10;
    localparam int unsigned SRC_H    = 6;
    localparam int unsigned DST_W    = 24;
    localparam int unsigned DST_H    = 14;
    localparam int unsigned SRC_BASE = 16;
    localparam int unsigned DST_BASE = 8;
    localparam int unsigned RD_LAT   = 2;
    localparam int unsigned MEM_SZ   = 1 << ADDR_W;

    localparam logic [2:0] OP_RD    = 3'b001;
    localparam logic [2:0] OP_WR    = 3'b010;
    localparam logic [2:0] OP_ZOOM2 = 3'b011;
    localparam logic [2:0] OP_DEC2  = 3'b100;
    localparam logic [2:0] OP_AVG2  = 3'b101;
    localparam logic [2:0] OP_COPY  = 3'b110;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              start;
    logic [2:0]        operation;
    logic              abort;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] data_in;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic [DATA_W-1:0] data_out;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] pix_count;
    logic [2:0]        state_dbg;

    always #5 clock = ~clock;

    scale_mem_ctrl #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .SRC_W    (SRC_W),
        .SRC_H    (SRC_H),
        .DST_W    (DST_W),
        .DST_H    (DST_H),
        .SRC_BASE (SRC_BASE),
        .DST_BASE (DST_BASE),
        .RD_LAT   (RD_LAT)
    ) u_dut (
        .i_clock     (clock),
        .i_reset_n   (reset_n),
        .i_start     (start),
        .i_operation (operation),
        .i_abort     (abort),
        .i_addr_in   (addr_in),
        .i_data_in   (data_in),
        .o_rd_addr   (rd_addr),
        .i_rd_data   (rd_data),
        .o_wr_addr   (wr_addr),
        .o_wr_data   (wr_data),
        .o_wr_en     (wr_en),
        .o_data_out  (data_out),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err),
        .o_pix_count (pix_count),
        .o_state_dbg (state_dbg)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int          cyc     = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Read RAM: address seen in cycle c appears on rd_data from mid-cycle c+RD_LAT
    logic [DATA_W-1:0] src_mem [MEM_SZ];
    logic [DATA_W-1:0] rd_pipe [RD_LAT+1];

    always @(negedge clock) begin
        rd_pipe[0] <= src_mem[rd_addr];
        for (int i = 1; i <= RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign rd_data = rd_pipe[RD_LAT];

    // Write RAM monitor
    logic [ADDR_W-1:0] wq_addr [$];
    logic [DATA_W-1:0] wq_data [$];

    always @(negedge clock) begin
        if (wr_en) begin
            wq_addr.push_back(wr_addr);
            wq_data.push_back(wr_data);
        end
    end

    // Reference model
    logic [ADDR_W-1:0] exp_addr [$];
    logic [DATA_W-1:0] exp_data [$];

    function automatic int out_w(input logic [2:0] op);
        if (op == OP_ZOOM2) return 2 * SRC_W;
        if (op == OP_DEC2 || op == OP_AVG2) return SRC_W / 2;
        return SRC_W;
    endfunction

    function automatic int out_h(input logic [2:0] op);
        if (op == OP_ZOOM2) return 2 * SRC_H;
        if (op == OP_DEC2 || op == OP_AVG2) return SRC_H / 2;
        return SRC_H;
    endfunction

    function automatic int px_cost(input logic [2:0] op);
        return ((op == OP_AVG2) ? 4 : 1) * (1 + RD_LAT) + 1;
    endfunction

    function automatic int src_at(input int x, input int y);
        return int'(src_mem[(SRC_BASE + y * SRC_W + x) % MEM_SZ]);
    endfunction

    task automatic build_expected(input logic [2:0] op);
        int ow, oh, offx, offy, v;
        exp_addr.delete();
        exp_data.delete();
        ow   = out_w(op);
        oh   = out_h(op);
        offx = (DST_W - ow) / 2;
        offy = (DST_H - oh) / 2;
        for (int oy = 0; oy < oh; oy++) begin
            for (int ox = 0; ox < ow; ox++) begin
                case (op)
                    OP_ZOOM2: v = src_at(ox / 2, oy / 2);
                    OP_DEC2:  v = src_at(2 * ox, 2 * oy);
                    OP_AVG2:  v = (src_at(2 * ox, 2 * oy) + src_at(2 * ox + 1, 2 * oy) +
                                   src_at(2 * ox, 2 * oy + 1) + src_at(2 * ox + 1, 2 * oy + 1)) / 4;
                    default:  v = src_at(ox, oy);
                endcase
                exp_addr.push_back(ADDR_W'((DST_BASE + (oy + offy) * DST_W + ox + offx) % MEM_SZ));
                exp_data.push_back(DATA_W'(v));
            end
        end
    endtask

    task automatic compare_writes(input string tag, input int n);
        int nbad  = 0;
        int first = -1;
        check_eq({tag, "_count"}, wq_addr.size(), n);
        for (int i = 0; i < n && i < wq_addr.size(); i++) begin
            if (wq_addr[i] !== exp_addr[i] || wq_data[i] !== exp_data[i]) begin
                nbad++;
                if (first < 0) first = i;
            end
        end
        check_eq({tag, "_bad_entries"}, nbad, 0);
        if (first >= 0) begin
            check_eq({tag, "_first_bad_addr"}, wq_addr[first], exp_addr[first]);
            check_eq({tag, "_first_bad_data"}, wq_data[first], exp_data[first]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rd_addr"}, rd_addr, 0);
        check_eq({tag, "_wr_addr"}, wr_addr, 0);
        check_eq({tag, "_wr_data"}, wr_data, 0);
        check_eq({tag, "_wr_en"}, wr_en, 0);
        check_eq({tag, "_data_out"}, data_out, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_err"}, err, 0);
        check_eq({tag, "_pix_count"}, pix_count, 0);
        check_eq({tag, "_state"}, state_dbg, 0);
    endtask

    // Returns cycle number of the accepting edge
    task automatic issue(input logic [2:0] op, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, output int acc_cyc);
        @(posedge clock); #1;
        start     = 1'b1;
        operation = op;
        addr_in   = a;
        data_in   = d;
        @(posedge clock); #1;
        start   = 1'b0;
        acc_cyc = cyc;
    endtask

    // Latency in cycles from the accepting edge to done, -1 if the budget expires
    task automatic wait_done(input int acc_cyc, input int budget, output int lat);
        lat = -1;
        for (int i = 0; i <= budget; i++) begin
            if (done) begin
                lat = cyc - acc_cyc;
                break;
            end
            @(posedge clock); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s, lat, n0, a, nexp;
        logic [2:0] op;
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rv;
        logic [2:0] frame_ops [4];
        frame_ops = '{OP_ZOOM2, OP_DEC2, OP_AVG2, OP_COPY};

        reset_n = 1'b0; start = 1'b0; operation = '0; abort = 1'b0; addr_in = '0; data_in = '0;
        for (int i = 0; i < MEM_SZ; i++) src_mem[i] = DATA_W'($urandom);
        for (int i = 0; i <= RD_LAT; i++) rd_pipe[i] = '0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // Single write
        wq_addr.delete(); wq_data.delete();
        issue(OP_WR, ADDR_W'(5), 8'hAB, s);
        check_eq("wr_busy", busy, 1);
        wait_done(s, 10, lat);
        check_eq("wr_latency", lat, 1);
        check_eq("wr_err", err, 0);
        check_eq("wr_pix_count", pix_count, 1);
        check_eq("wr_count", wq_addr.size(), 1);
        if (wq_addr.size() > 0) begin
            check_eq("wr_addr", wq_addr[0], 5);
            check_eq("wr_data", wq_data[0], 8'hAB);
        end
        @(posedge clock); #1;
        check_eq("done_one_cycle", done, 0);
        check_eq("back_to_idle", state_dbg, 0);

        // Single reads: fixed case, then random addresses
        src_mem[7] = 8'h3C;
        for (int t = 0; t < 5; t++) begin
            ra = (t == 0) ? ADDR_W'(7) : ADDR_W'($urandom_range(0, MEM_SZ - 1));
            rv = src_mem[ra];
            wq_addr.delete(); wq_data.delete();
            issue(OP_RD, ra, DATA_W'($urandom), s);
            wait_done(s, 20, lat);
            check_eq("rd_latency", lat, 1 + RD_LAT);
            check_eq("rd_data_out", data_out, rv);
            check_eq("rd_err", err, 0);
            check_eq("rd_no_write", wq_addr.size(), 0);
        end

        // Reserved opcodes
        for (int t = 0; t < 2; t++) begin
            ra = rd_addr;
            wq_addr.delete(); wq_data.delete();
            issue((t == 0) ? 3'b000 : 3'b111, ADDR_W'($urandom), DATA_W'($urandom), s);
            wait_done(s, 5, lat);
            check_eq("rsv_latency", lat, 0);
            check_eq("rsv_err", err, 1);
            check_eq("rsv_busy", busy, 0);
            check_eq("rsv_rd_addr_held", rd_addr, ra);
            check_eq("rsv_no_write", wq_addr.size(), 0);
        end

        // Full frame passes on fresh random images
        for (int f = 0; f < 4; f++) begin
            op = frame_ops[f];
            for (int i = 0; i < MEM_SZ; i++) src_mem[i] = DATA_W'($urandom);
            if (op == OP_AVG2) begin
                src_mem[SRC_BASE]         = 8'd10;
                src_mem[SRC_BASE + 1]     = 8'd20;
                src_mem[SRC_BASE + SRC_W] = 8'd30;
                src_mem[SRC_BASE + SRC_W + 1] = 8'd41;
            end
            build_expected(op);
            wq_addr.delete(); wq_data.delete();
            issue(op, '0, '0, s);
            if (op == OP_COPY) begin
                // A second start mid-frame must be ignored
                repeat (10) @(posedge clock);
                #1;
                start = 1'b1; operation = OP_WR;
                @(posedge clock); #1;
                start = 1'b0;
                check_eq("copy_busy_during", busy, 1);
            end
            wait_done(s, out_w(op) * out_h(op) * px_cost(op) + 20, lat);
            check_eq($sformatf("frame%0d_latency", op), lat, out_w(op) * out_h(op) * px_cost(op));
            check_eq($sformatf("frame%0d_err", op), err, 0);
            check_eq($sformatf("frame%0d_pix_count", op), pix_count, out_w(op) * out_h(op));
            compare_writes($sformatf("frame%0d", op), exp_addr.size());
            if (op == OP_AVG2 && wq_data.size() > 0) begin
                check_eq("avg_first_data", wq_data[0], 25);
                check_eq("avg_first_addr", wq_addr[0],
                         DST_BASE + ((DST_H - SRC_H / 2) / 2) * DST_W + (DST_W - SRC_W / 2) / 2);
            end
        end

        // Abort a COPY after 25 completed writes
        build_expected(OP_COPY);
        wq_addr.delete(); wq_data.delete();
        issue(OP_COPY, '0, '0, s);
        for (int i = 0; i < 500 && wq_addr.size() < 25; i++) begin
            @(posedge clock); #1;
        end
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        check_eq("abort_done", done, 1);
        check_eq("abort_err", err, 1);
        check_eq("abort_pix_count", pix_count, 25);
        repeat (20) @(posedge clock);
        #1;
        compare_writes("abort_copy", 25);

        // Abort at random points, including while a write is being prepared
        for (int t = 0; t < 4; t++) begin
            op = frame_ops[$urandom_range(0, 3)];
            a  = $urandom_range(0, 50);
            nexp = (a + 1) / px_cost(op);
            build_expected(op);
            wq_addr.delete(); wq_data.delete();
            issue(op, '0, '0, s);
            repeat (a) @(posedge clock);
            #1;
            abort = 1'b1;
            @(posedge clock); #1;
            abort = 1'b0;
            check_eq("rabort_done", done, 1);
            check_eq("rabort_err", err, 1);
            check_eq("rabort_pix_count", pix_count, nexp);
            repeat (15) @(posedge clock);
            #1;
            compare_writes("rabort", nexp);
        end

        // Abort together with start while idle: start is dropped
        @(posedge clock); #1;
        start = 1'b1; abort = 1'b1; operation = OP_COPY;
        @(posedge clock); #1;
        start = 1'b0; abort = 1'b0;
        check_eq("idle_abort_busy", busy, 0);
        check_eq("idle_abort_done", done, 0);
        check_eq("idle_abort_state", state_dbg, 0);
        @(posedge clock); #1;
        check_eq("idle_abort_no_done", done, 0);

        // Reset in the middle of a ZOOM2 pass
        wq_addr.delete(); wq_data.delete();
        issue(OP_ZOOM2, '0, '0, s);
        repeat (50) @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(posedge clock); #1;
        check_reset_outputs("midreset");
        n0 = wq_addr.size();
        reset_n = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        check_eq("midreset_no_write", wq_addr.size(), n0);
        check_eq("midreset_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
